// File: rtl/nand_nb_pkg.sv
// Shared encodings and limits for the nand_nb_pipe reduction gate.
package nand_nb_pkg;

  localparam logic [1:0] MODE_AND  = 2'b00;
  localparam logic [1:0] MODE_NAND = 2'b01;
  localparam logic [1:0] MODE_OR   = 2'b10;
  localparam logic [1:0] MODE_NOR  = 2'b11;

  localparam int unsigned MAX_LATENCY = 4;
  localparam int unsigned MAX_WIDTH   = 32;

  // One pipeline slot: gate result plus its valid tag.
  typedef struct packed {
    logic data;
    logic valid;
  } stage_t;

endpackage

// File: rtl/nand_nb_pipe_stage.sv
// Single clock-enabled {data, valid} pipeline register with synchronous reset.
module nand_nb_pipe_stage
  import nand_nb_pkg::*;
#(
  parameter logic INIT = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   ce,
  input  stage_t d,
  output stage_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q.data  <= INIT;
      q.valid <= 1'b0;
    end else if (ce) begin
      q <= d;
    end
  end

endmodule

// File: rtl/nand_nb_pipe.sv
// N-input masked AND/NAND/OR/NOR gate with a registered pipeline of LATENCY stages.
// Optional toggle counter on O enabled by NAND_NB_PIPE_TOGGLE_CNT_EN.
module nand_nb_pipe
  import nand_nb_pkg::*;
#(
  parameter int unsigned          WIDTH    = 5,
  parameter logic [WIDTH-1:0]     INV_MASK = WIDTH'(5'b00111),
  parameter int unsigned          LATENCY  = 1,
  parameter logic                 INIT     = 1'b1
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
  input  logic [WIDTH-1:0] I,
  input  logic             VI,
  input  logic [1:0]       MODE,
  input  logic             MASK_LD,
  input  logic [WIDTH-1:0] MASK_D,
  output logic             O,
  output logic             VO,
  output logic [WIDTH-1:0] MASK_Q
`ifdef NAND_NB_PIPE_TOGGLE_CNT_EN
  ,
  input  logic             TCNT_CLR,
  output logic [15:0]      TCNT
`endif
);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $fatal(1, "nand_nb_pipe: LATENCY must be 1..4");
  end
  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $fatal(1, "nand_nb_pipe: WIDTH must be 2..32");
  end

  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] x;
  logic             f;
  stage_t           chain [LATENCY+1];

  // Mask reload is deliberately not gated by CE.
  always_ff @(posedge C) begin
    if (R) begin
      mask_r <= INV_MASK;
    end else if (MASK_LD) begin
      mask_r <= MASK_D;
    end
  end

  assign MASK_Q = mask_r;

  // Masked reduction selected by MODE.
  always_comb begin
    x = I ^ mask_r;
    f = 1'b0;
    case (MODE)
      MODE_AND:  f = &x;
      MODE_NAND: f = ~&x;
      MODE_OR:   f = |x;
      MODE_NOR:  f = ~|x;
      default:   f = 1'b0;
    endcase
  end

  assign chain[0].data  = f;
  assign chain[0].valid = VI;

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    nand_nb_pipe_stage #(
      .INIT (INIT)
    ) u_stage (
      .clk (C),
      .rst (R),
      .ce  (CE),
      .d   (chain[k]),
      .q   (chain[k+1])
    );
  end

  assign O  = chain[LATENCY].data;
  assign VO = chain[LATENCY].valid;

`ifdef NAND_NB_PIPE_TOGGLE_CNT_EN
  logic [15:0] tcnt_r;
  logic        next_o;
  logic        next_vo;

  // Values O/VO will take on the next enabled edge.
  assign next_o  = chain[LATENCY-1].data;
  assign next_vo = chain[LATENCY-1].valid;

  always_ff @(posedge C) begin
    if (R || TCNT_CLR) begin
      tcnt_r <= '0;
    end else if (CE && next_vo && (next_o != O) && (tcnt_r != 16'hFFFF)) begin
      tcnt_r <= tcnt_r + 16'd1;
    end
  end

  assign TCNT = tcnt_r;
`endif

endmodule

// File: tb/tb_nand_nb_pipe.sv
// Scoreboard bench for nand_nb_pipe at LATENCY 1, 2 and 3 driven by shared directed vectors.
module tb_nand_nb_pipe;
  import nand_nb_pkg::*;

  localparam int unsigned W    = 5;
  localparam int unsigned NDUT = 3;
  localparam logic [W-1:0] INV = 5'b00111;

  logic         C = 1'b0;
  logic         R = 1'b1;
  logic         CE = 1'b1;
  logic         VI = 1'b0;
  logic         MASK_LD = 1'b0;
  logic [W-1:0] I = '0;
  logic [W-1:0] MASK_D = '0;
  logic [1:0]   MODE = MODE_AND;
  logic         TCNT_CLR = 1'b0;
  logic         exp_o = 1'b0;

  logic         o_w    [NDUT];
  logic         vo_w   [NDUT];
  logic [W-1:0] mq_w   [NDUT];
  logic [15:0]  tcnt_w [NDUT];

  typedef struct {
    logic        o;
    int unsigned due;
  } exp_t;

  exp_t         q [NDUT][$];
  int unsigned  en_edges = 0;
  int           edge_kind = 3;
  logic [W-1:0] exp_mask = INV;
  logic         last_vo [NDUT];
  logic         last_o  [NDUT];
  int           total = 0;
  int           bad = 0;

  always #5 C = ~C;

  for (genvar j = 0; j < NDUT; j++) begin : g_dut
    nand_nb_pipe #(
      .WIDTH    (W),
      .INV_MASK (INV),
      .LATENCY  (j + 1),
      .INIT     (1'b1)
    ) u_dut (
      .C        (C),
      .R        (R),
      .CE       (CE),
      .I        (I),
      .VI       (VI),
      .MODE     (MODE),
      .MASK_LD  (MASK_LD),
      .MASK_D   (MASK_D),
      .O        (o_w[j]),
      .VO       (vo_w[j]),
      .MASK_Q   (mq_w[j])
`ifdef NAND_NB_PIPE_TOGGLE_CNT_EN
      ,
      .TCNT_CLR (TCNT_CLR),
      .TCNT     (tcnt_w[j])
`endif
    );
`ifndef NAND_NB_PIPE_TOGGLE_CNT_EN
    assign tcnt_w[j] = '0;
`endif
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h at %0t", nm, idx, act, want, $time);
    end
  endtask

  // Issue side: push the hand-computed result of every captured valid sample.
  always @(posedge C) begin
    if (R) begin
      for (int j = 0; j < NDUT; j++) q[j].delete();
      exp_mask  <= INV;
      edge_kind <= 2;
    end else begin
      if (MASK_LD) exp_mask <= MASK_D;
      if (CE) begin
        en_edges  <= en_edges + 1;
        edge_kind <= 1;
        if (VI) begin
          for (int j = 0; j < NDUT; j++) begin
            exp_t e;
            e.o   = exp_o;
            e.due = en_edges + 1 + j;
            q[j].push_back(e);
          end
        end
      end else begin
        edge_kind <= 0;
      end
    end
  end

  // Monitor side: compare outputs half a cycle after each edge.
  always @(negedge C) begin
    for (int j = 0; j < NDUT; j++) begin
      logic ev;
      ev = 1'b0;
      if (edge_kind == 2) begin
        chk("rst_vo", j, 32'(vo_w[j]), 32'd0);
        chk("rst_o", j, 32'(o_w[j]), 32'd1);
        last_vo[j] <= 1'b0;
      end else if (edge_kind == 1) begin
        while (q[j].size() > 0 && q[j][0].due < en_edges) begin
          total++;
          bad++;
          $display("FAIL missing_vo[%0d] got=none want=sample due at edge %0d", j, q[j][0].due);
          void'(q[j].pop_front());
        end
        ev = (q[j].size() > 0) && (q[j][0].due == en_edges);
        chk("vo", j, 32'(vo_w[j]), 32'(ev));
        if (ev) begin
          chk("o", j, 32'(o_w[j]), 32'(q[j][0].o));
          last_o[j] <= q[j][0].o;
          void'(q[j].pop_front());
        end
        last_vo[j] <= ev;
      end else if (edge_kind == 0) begin
        chk("hold_vo", j, 32'(vo_w[j]), 32'(last_vo[j]));
        if (last_vo[j]) chk("hold_o", j, 32'(o_w[j]), 32'(last_o[j]));
      end
      if (edge_kind != 3) chk("mask_q", j, 32'(mq_w[j]), 32'(exp_mask));
    end
  end

  task automatic cyc(input logic [W-1:0] i, input logic [1:0] m, input logic v, input logic e);
    I     = i;
    MODE  = m;
    VI    = v;
    exp_o = e;
    @(posedge C);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge C);
    #1;
    R = 1'b0;

    // Legacy 5-input NAND with three inverted inputs.
    cyc(5'b11000, MODE_NAND, 1'b1, 1'b0);
    cyc(5'b11001, MODE_NAND, 1'b1, 1'b1);

    // Mask load: load-edge sample uses the old mask, the next one the new.
    MASK_LD = 1'b1;
    MASK_D  = 5'b00000;
    cyc(5'b11000, MODE_NAND, 1'b1, 1'b0);
    MASK_LD = 1'b0;
    chk("mask_after_ld", 0, 32'(mq_w[0]), 32'd0);
    cyc(5'b11000, MODE_NAND, 1'b1, 1'b1);

    // Isolated valid pulse for latency alignment.
    cyc(5'b11111, MODE_AND, 1'b1, 1'b1);
    repeat (5) cyc(5'b00000, MODE_AND, 1'b0, 1'b0);

    // Remaining modes with mask = 0.
    cyc(5'b00000, MODE_OR,  1'b1, 1'b0);
    cyc(5'b00000, MODE_NOR, 1'b1, 1'b1);
    cyc(5'b00100, MODE_OR,  1'b1, 1'b1);
    cyc(5'b10000, MODE_NOR, 1'b1, 1'b0);
    cyc(5'b11110, MODE_AND, 1'b1, 1'b0);

    // Clock-enable freeze mid-stream.
    cyc(5'b11111, MODE_AND,  1'b1, 1'b1);
    cyc(5'b11111, MODE_NAND, 1'b1, 1'b0);
    CE = 1'b0;
    repeat (4) cyc(5'b11111, MODE_AND, 1'b1, 1'b1);
    CE = 1'b1;
    cyc(5'b00000, MODE_OR,  1'b1, 1'b0);
    cyc(5'b00000, MODE_NOR, 1'b1, 1'b1);
    repeat (4) cyc(5'b00000, MODE_AND, 1'b0, 1'b0);

    // Reset with samples in flight and a competing mask load.
    cyc(5'b11111, MODE_AND, 1'b1, 1'b1);
    cyc(5'b00000, MODE_NOR, 1'b1, 1'b1);
    R       = 1'b1;
    MASK_LD = 1'b1;
    MASK_D  = 5'b11111;
    cyc(5'b00000, MODE_AND, 1'b0, 1'b0);
    R       = 1'b0;
    MASK_LD = 1'b0;
    for (int j = 0; j < NDUT; j++) begin
      chk("rst_mid_o", j, 32'(o_w[j]), 32'd1);
      chk("rst_mid_vo", j, 32'(vo_w[j]), 32'd0);
      chk("rst_mid_mask", j, 32'(mq_w[j]), 32'(INV));
    end
    repeat (4) cyc(5'b00000, MODE_AND, 1'b0, 1'b0);

`ifdef NAND_NB_PIPE_TOGGLE_CNT_EN
    // Toggle counter on the LATENCY=1 instance; mask back to 00111 after reset.
    R = 1'b1;
    cyc(5'b00000, MODE_AND, 1'b0, 1'b0);
    R = 1'b0;
    chk("tcnt_rst", 0, 32'(tcnt_w[0]), 32'd0);
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) cyc(5'b11000, MODE_AND, 1'b1, 1'b1);
      else            cyc(5'b00000, MODE_AND, 1'b1, 1'b0);
    end
    chk("tcnt_alt10", 0, 32'(tcnt_w[0]), 32'd9);
    TCNT_CLR = 1'b1;
    cyc(5'b11000, MODE_AND, 1'b1, 1'b1);
    TCNT_CLR = 1'b0;
    chk("tcnt_clr_wins", 0, 32'(tcnt_w[0]), 32'd0);
    for (int k = 0; k < 70000; k++) begin
      if (k % 2 == 0) cyc(5'b00000, MODE_AND, 1'b1, 1'b0);
      else            cyc(5'b11000, MODE_AND, 1'b1, 1'b1);
    end
    chk("tcnt_sat", 0, 32'(tcnt_w[0]), 32'h0000FFFF);
`endif

    repeat (5) cyc(5'b00000, MODE_AND, 1'b0, 1'b0);
    for (int j = 0; j < NDUT; j++) chk("drain", j, 32'(q[j].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nand_nb_pipe.md
Name: nand_nb_pipe

Overview:
- Parametrised successor to the fixed-width, fixed-inversion NAND primitives: an N-input reduction gate with a per-input inversion mask.
- Mask is a parameter default and can be reloaded at run time.
- Mode is selectable at run time: AND/NAND/OR/NOR.
- Result passes through a registered pipeline of programmable depth, with a valid tag and clock enable.
- Used as a timing-closed replacement for chains of unisim gate cells in registered datapaths.

Parameters:
- WIDTH, 5: number of gate inputs, 2..32.
- INV_MASK, 5'b00111: reset value of the inversion mask; bit k=1 inverts I[k] before the reduction.
- LATENCY, 1: pipeline depth in cycles, 1..4. Any other value is a fatal elaboration error.
- INIT, 1'b1: reset value of O and of every pipeline data stage.

Ports:
- C  in  1  clock, rising edge.
- R  in  1  synchronous active-high reset.
- CE  in  1  clock enable for the pipeline and the sample register.
- I  in  WIDTH  gate inputs.
- VI  in  1  input valid.
- MODE  in  2  gate function: 00 AND, 01 NAND, 10 OR, 11 NOR.
- MASK_LD  in  1  load the inversion mask from MASK_D.
- MASK_D  in  WIDTH  new inversion mask.
- O  out  1  gate result after LATENCY cycles.
- VO  out  1  valid aligned with O.
- MASK_Q  out  WIDTH  current inversion mask.

Behaviour:
- Reset (R=1 at a C edge) overrides CE and MASK_LD:
  - mask_r <= INV_MASK
  - all data stages <= INIT
  - all valid stages <= 0
  - O=INIT, VO=0, MASK_Q=INV_MASK.
- Combinational term: x = I ^ mask_r. Then:
  - f = &x for AND.
  - f = ~&x for NAND.
  - f = |x for OR.
  - f = ~|x for NOR.
  - MODE is sampled in the same cycle as I.
- Pipeline: with CE=1, stage0 <= {f, VI} and stage k <= stage k-1. O/VO are the last stage.
- Latency: O reflects the I/MODE presented exactly LATENCY enabled edges earlier.
- CE=0: every stage holds, O and VO unchanged. CE does not gate mask loading.
- Mask load: MASK_LD=1 at an edge (R=0) sets mask_r <= MASK_D, independent of CE.
  - The new mask applies to inputs sampled from the next edge on.
  - The sample taken at the load edge still uses the old mask.
- VI=0 samples are still computed and shifted; only VO marks them invalid. O is not forced to INIT.
- Reset mid-pipeline discards all in-flight samples. VO stays 0 for LATENCY enabled edges after R deasserts.
- No X-propagation masking: any X on I yields X on O for that sample only.

Optional Feature:
- Macro: NAND_NB_PIPE_TOGGLE_CNT_EN.
- When defined:
  - Adds output TCNT, 16 bits: counts enabled edges where O changes value while the new VO=1.
  - Saturates at 16'hFFFF.
  - Cleared by R.
  - Adds input TCNT_CLR, 1 bit: synchronous clear. If a clear and an increment coincide, clear wins.
- When undefined: TCNT and TCNT_CLR ports do not exist and there is no counter logic.

Decomposition:
- Shared package nand_nb_pkg holds:
  - MODE encodings: MODE_AND=2'b00, MODE_NAND=2'b01, MODE_OR=2'b10, MODE_NOR=2'b11.
  - MAX_LATENCY=4 and MAX_WIDTH=32.
- One natural sub-module, nand_nb_pipe_stage: a single CE-gated {data, valid} register with sync reset to {INIT, 0}. Instantiated LATENCY times in a generate loop.
- Reduction logic and the mask register stay in the top.

Test Plan:
- Defaults, MODE=01, I=5'b11000, VI=1, CE=1 -> next edge O=0, VO=1. This matches the legacy 5-input NAND with 3 inverted inputs. I=5'b11001 -> O=1.
- LATENCY=3, VI pulse with I=all ones, MODE=00, mask=0 -> O=1 and VO=1 exactly 3 edges later, VO=0 on the surrounding edges.
- MASK_LD=1 with MASK_D=5'b00000 in the same cycle as I=5'b11000, MODE=01:
  - That sample uses the old mask -> O=0.
  - The next sample of the same I uses the new mask -> O=1.
  - MASK_Q=0 after the edge.
- CE=0 for 4 cycles mid-stream (LATENCY=2) -> O/VO frozen. Resume: remaining samples emerge in order with no loss or duplication.
- R asserted with 2 valid samples in flight and MASK_LD=1 -> O=INIT, VO=0, MASK_Q=INV_MASK. VO=0 for LATENCY edges after release.
- With NAND_NB_PIPE_TOGGLE_CNT_EN defined:
  - Alternate O for 10 valid samples -> TCNT=9 (the first valid sample counts only if it differs from INIT).
  - TCNT_CLR and a toggle in the same cycle -> TCNT=0.
  - Forced 70000 toggles -> TCNT=16'hFFFF.
